// File: rtl/bin_erode.sv
// 3x3 binary erosion on a raster pixel stream (two line buffers feeding a 3x3 window).
// Define BIN_ERODE_DILATE_EN to build a 3x3 dilation instead (OR of taps, zero padding).
module bin_erode #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              ero_clk,
  input  logic              ero_rst,
  input  logic              ero_ctrl,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_data,
  output logic              out_valid,
  output logic              out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic [1:0]        condition_led
);

  localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FW   = $clog2(IMG_W + 1);
  localparam int NPIX = IMG_W * IMG_H;

  localparam logic [XW-1:0]     X_LAST     = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST     = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] CNT_LAST   = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] CNT_PRIME  = ADDR_W'(IMG_W + 1);
  localparam logic [FW-1:0]     FLUSH_LAST = FW'(IMG_W);

`ifdef BIN_ERODE_DILATE_EN
  localparam logic PAD = 1'b0;
`else
  localparam logic PAD = 1'b1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10,
    DONE  = 2'b11
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] inCnt_q;
  logic [ADDR_W-1:0] outCnt_q;
  logic [ADDR_W-1:0] outAddr_q;
  logic [XW-1:0]     bx_q;
  logic [XW-1:0]     ox_q;
  logic [YW-1:0]     oy_q;
  logic [FW-1:0]     flushCnt_q;
  logic              outValid_q;
  logic              outData_q;
  logic              lineBuf0_q [IMG_W];
  logic              lineBuf1_q [IMG_W];

  // Only the two older window columns are stored; the newest column comes straight
  // from the line buffers and the incoming beat.
  logic [2:0][1:0]   win_q;
  logic [2:0][1:0]   win_d;
  logic [2:0][2:0]   tap_d;
  logic              start_d;
  logic              beat_d;
  logic              emit_d;
  logic              pix_d;
  logic              result_d;

  always_comb begin
    start_d = ero_ctrl && ((state_q == IDLE) || (state_q == DONE));
    beat_d  = ((state_q == RUN) && in_valid) || (state_q == FLUSH);
    pix_d   = (state_q == RUN) ? in_data : PAD;
    emit_d  = beat_d && ((state_q == FLUSH) || (inCnt_q >= CNT_PRIME));

    tap_d = '0;
    win_d = '0;
    for (int r = 0; r < 3; r++) begin
      tap_d[r][0] = win_q[r][0];
      tap_d[r][1] = win_q[r][1];
    end
    tap_d[0][2] = lineBuf1_q[bx_q];
    tap_d[1][2] = lineBuf0_q[bx_q];
    tap_d[2][2] = pix_d;
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = tap_d[r][1];
      win_d[r][1] = tap_d[r][2];
    end

    // The window is centred on output pixel (ox,oy); taps outside the frame are padded,
    // which also hides the previous row's tail when the centre sits on column 0.
    if (ox_q == '0) begin
      for (int r = 0; r < 3; r++) tap_d[r][0] = PAD;
    end
    if (ox_q == X_LAST) begin
      for (int r = 0; r < 3; r++) tap_d[r][2] = PAD;
    end
    if (oy_q == '0)    tap_d[0] = {3{PAD}};
    if (oy_q == Y_LAST) tap_d[2] = {3{PAD}};

`ifdef BIN_ERODE_DILATE_EN
    result_d = |tap_d;
`else
    result_d = &tap_d;
`endif
  end

  always_ff @(posedge ero_clk) begin
    if (ero_rst) begin
      state_q    <= IDLE;
      inCnt_q    <= '0;
      outCnt_q   <= '0;
      outAddr_q  <= '0;
      bx_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      flushCnt_q <= '0;
      win_q      <= '0;
      outValid_q <= 1'b0;
      outData_q  <= 1'b0;
      for (int i = 0; i < IMG_W; i++) begin
        lineBuf0_q[i] <= 1'b0;
        lineBuf1_q[i] <= 1'b0;
      end
    end else begin
      outValid_q <= emit_d;

      if (start_d) begin
        state_q    <= RUN;
        inCnt_q    <= '0;
        outCnt_q   <= '0;
        bx_q       <= '0;
        ox_q       <= '0;
        oy_q       <= '0;
        flushCnt_q <= '0;
        win_q      <= '0;
      end

      if (beat_d) begin
        win_q            <= win_d;
        lineBuf1_q[bx_q] <= lineBuf0_q[bx_q];
        lineBuf0_q[bx_q] <= pix_d;
        bx_q             <= (bx_q == X_LAST) ? '0 : bx_q + 1'b1;
      end

      if (emit_d) begin
        outData_q <= result_d;
        outAddr_q <= outCnt_q;
        if (outCnt_q != CNT_LAST) outCnt_q <= outCnt_q + 1'b1;
        if (ox_q == X_LAST) begin
          ox_q <= '0;
          if (oy_q != Y_LAST) oy_q <= oy_q + 1'b1;
        end else begin
          ox_q <= ox_q + 1'b1;
        end
      end

      case (state_q)
        RUN: begin
          if (in_valid) begin
            if (inCnt_q == CNT_LAST) begin
              state_q    <= FLUSH;
              flushCnt_q <= '0;
            end else begin
              inCnt_q <= inCnt_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (flushCnt_q == FLUSH_LAST) state_q <= DONE;
          else flushCnt_q <= flushCnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = (state_q == RUN);
  assign out_valid     = outValid_q;
  assign out_data      = outData_q;
  assign out_addr      = outAddr_q;
  assign condition_led = state_q;

endmodule
